// File: rtl/pcap_dma_buffer_if.sv
// DMA-side burst port: a request/acknowledge carrying the burst length,
// followed by valid/ready data beats with a last-beat marker.
interface pcap_dma_buffer_if;
  logic        m_req_o;
  logic [7:0]  m_len_o;
  logic        m_ack_i;
  logic [31:0] m_dat_o;
  logic        m_dat_valid_o;
  logic        m_dat_ready_i;
  logic        m_last_o;

  modport master (
    output m_req_o, m_len_o, m_dat_o, m_dat_valid_o, m_last_o,
    input  m_ack_i, m_dat_ready_i
  );

  modport slave (
    input  m_req_o, m_len_o, m_dat_o, m_dat_valid_o, m_last_o,
    output m_ack_i, m_dat_ready_i
  );
endinterface

// File: rtl/pcap_dma_buffer.sv
// Capture-word FIFO that hands data to the DMA engine as fixed-length bursts,
// with high-water back-pressure, sticky overflow and end-of-capture flush.
module pcap_dma_buffer #(
  parameter int DEPTH      = 1024,
  parameter int BURST      = 16,
  parameter int HIGH_WATER = DEPTH - 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     pcap_start_i,
  input  logic [31:0]              pcap_dat_i,
  input  logic                     pcap_dat_valid_i,
  input  logic                     pcap_done_i,
  output logic                     dma_full_o,
  pcap_dma_buffer_if.master        dma,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     overflow_o,
  output logic                     flush_done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   BURST_LVL = (AW+1)'(BURST);
  localparam logic [AW:0]   HW_LVL    = (AW+1)'(HIGH_WATER);
  localparam logic [AW:0]   FILL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [7:0]    BURST_LEN = 8'(BURST);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t          state, state_next;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     fill, fill_next;
  logic [7:0]      len, len_next;
  logic [7:0]      beats, beats_next;
  logic            flush_pending, flush_pending_next;
  logic            flush_done_next;
  logic            clear, full, in_xfer, beat, wr_en, rd_en;

  // Arm and reset share one clear path; it wins over any same-cycle write or done.
  assign clear   = reset_i | pcap_start_i;
  assign full    = (fill == DEPTH_LVL);
  assign in_xfer = (state == XFER);
  assign beat    = in_xfer & dma.m_dat_ready_i;
  assign wr_en   = pcap_dat_valid_i & ~full & ~clear;
  assign rd_en   = beat & ~clear;

  always_comb begin
    fill_next = fill;
    if (clear)
      fill_next = '0;
    else if (wr_en && !rd_en)
      fill_next = fill + FILL_ONE;
    else if (rd_en && !wr_en)
      fill_next = fill - FILL_ONE;
  end

  // Storage holds data only and is never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en)
      mem[wr_ptr] <= pcap_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      overflow_o <= 1'b0;
      dma_full_o <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en)
        rd_ptr <= rd_ptr + PTR_ONE;
      fill       <= fill_next;
      overflow_o <= overflow_o | (pcap_dat_valid_i & full);
      dma_full_o <= (fill_next >= HW_LVL);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      state         <= IDLE;
      len           <= '0;
      beats         <= '0;
      flush_pending <= 1'b0;
      flush_done_o  <= 1'b0;
    end else begin
      state         <= state_next;
      len           <= len_next;
      beats         <= beats_next;
      flush_pending <= flush_pending_next;
      flush_done_o  <= flush_done_next;
    end
  end

  // Full bursts take priority, so a flush drains whole bursts before the partial one.
  always_comb begin
    state_next         = state;
    len_next           = len;
    beats_next         = beats;
    flush_pending_next = flush_pending | pcap_done_i;
    flush_done_next    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fill >= BURST_LVL) begin
          state_next = REQ;
          len_next   = BURST_LEN;
        end else if (flush_pending && fill != '0) begin
          state_next = REQ;
          len_next   = 8'(fill);
        end else if (flush_pending) begin
          flush_done_next    = 1'b1;
          flush_pending_next = pcap_done_i;
        end
      end
      REQ: begin
        if (dma.m_ack_i) begin
          state_next = XFER;
          beats_next = len;
        end
      end
      XFER: begin
        if (beat) begin
          beats_next = beats - 8'd1;
          if (beats == 8'd1)
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign dma.m_req_o       = (state == REQ);
  assign dma.m_len_o       = len;
  assign dma.m_dat_valid_o = in_xfer;
  assign dma.m_last_o      = in_xfer & (beats == 8'd1);
  assign dma.m_dat_o       = mem[rd_ptr];
  assign fill_o            = fill;

endmodule

// File: tb/tb_pcap_dma_buffer.sv
// Directed bench for pcap_dma_buffer: a vector table for the partial-flush
// sequence plus hand-written burst, back-pressure, overflow and abort sequences.
module tb_pcap_dma_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, pcap_start, pcap_dat_valid, pcap_done;
  logic [31:0] pcap_dat;
  logic        dma_full, overflow, flush_done;
  logic [10:0] fill;

  pcap_dma_buffer_if dma();

  pcap_dma_buffer #(.DEPTH(1024), .BURST(16), .HIGH_WATER(1008)) dut (
    .clk_i(clk), .reset_i(reset), .pcap_start_i(pcap_start),
    .pcap_dat_i(pcap_dat), .pcap_dat_valid_i(pcap_dat_valid),
    .pcap_done_i(pcap_done), .dma_full_o(dma_full), .dma(dma),
    .fill_o(fill), .overflow_o(overflow), .flush_done_o(flush_done)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] rx_dat[$];
  logic        rx_last[$];
  logic [7:0]  rx_len[$];
  logic        track_en = 1'b0;
  int          tw = 0, tbt = 0, track_bad = 0;

  // Beat/request recorder and occupancy tracker, sampled mid-cycle.
  always @(negedge clk) begin
    if (dma.m_req_o && dma.m_ack_i) rx_len.push_back(dma.m_len_o);
    if (dma.m_dat_valid_o && dma.m_dat_ready_i) begin
      rx_dat.push_back(dma.m_dat_o);
      rx_last.push_back(dma.m_last_o);
    end
    if (track_en) begin
      if (int'(fill) != tw - tbt) track_bad++;
      if (pcap_dat_valid) tw++;
      if (dma.m_dat_valid_o && dma.m_dat_ready_i) tbt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      pcap_dat_valid = 1'b1;
      pcap_dat = 32'(base + i);
      cycle();
    end
    pcap_dat_valid = 1'b0;
  endtask

  task automatic clear_rx();
    rx_dat.delete();
    rx_last.delete();
    rx_len.delete();
  endtask

  task automatic wait_flush_done(input string name, input int budget, input bit rnd_ready);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (flush_done) found = 1'b1;
      else begin
        if (rnd_ready) dma.m_dat_ready_i = 1'($urandom_range(0, 1));
        cycle();
      end
    end
    chk(name, 64'(found), 64'd1);
    dma.m_dat_ready_i = 1'b1;
    cycle();
  endtask

  task automatic wait_rx(input string name, input int n, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (rx_dat.size() >= n) found = 1'b1;
      else cycle();
    end
    chk(name, 64'(found), 64'd1);
    cycle();
  endtask

  // Received stream must be base, base+1, ... with last at every burst end.
  task automatic check_rx(input string name, input int base, input int n, input int blen);
    int bad_dat = 0;
    int bad_last = 0;
    chk({name, "_count"}, 64'(rx_dat.size()), 64'(n));
    for (int i = 0; i < rx_dat.size(); i++) begin
      if (rx_dat[i] !== 32'(base + i)) bad_dat++;
      if (rx_last[i] !== ((i % blen) == blen - 1 || i == n - 1)) bad_last++;
    end
    chk({name, "_order"}, 64'(bad_dat), 64'd0);
    chk({name, "_last"}, 64'(bad_last), 64'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] dat;
    logic        done;
    logic [10:0] fill;
    logic        req;
    logic [7:0]  len;
    logic        vld;
    logic        last;
    logic [31:0] mdat;
    logic        fdone;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [31:0] dat, input logic done,
                              input logic [10:0] f, input logic req, input logic [7:0] len,
                              input logic vld, input logic last, input logic [31:0] mdat,
                              input logic fdone);
    vec_t v;
    v.wr = wr; v.dat = dat; v.done = done; v.fill = f; v.req = req; v.len = len;
    v.vld = vld; v.last = last; v.mdat = mdat; v.fdone = fdone;
    return v;
  endfunction

  vec_t vt[19];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [54:0] act, exp;
    int bad_len;
    int fd;
    bit found;

    // Partial flush of 5 words, then a flush with the FIFO empty (ack/ready high).
    vt[0]  = mk(1, 32'hA0, 0,  0, 0, 0, 0, 0, 0,      0);
    vt[1]  = mk(1, 32'hA1, 0,  1, 0, 0, 0, 0, 0,      0);
    vt[2]  = mk(1, 32'hA2, 0,  2, 0, 0, 0, 0, 0,      0);
    vt[3]  = mk(1, 32'hA3, 0,  3, 0, 0, 0, 0, 0,      0);
    vt[4]  = mk(1, 32'hA4, 0,  4, 0, 0, 0, 0, 0,      0);
    vt[5]  = mk(0, 0,      1,  5, 0, 0, 0, 0, 0,      0);
    vt[6]  = mk(0, 0,      0,  5, 0, 0, 0, 0, 0,      0);
    vt[7]  = mk(0, 0,      0,  5, 1, 5, 0, 0, 0,      0);
    vt[8]  = mk(0, 0,      0,  5, 0, 0, 1, 0, 32'hA0, 0);
    vt[9]  = mk(0, 0,      0,  4, 0, 0, 1, 0, 32'hA1, 0);
    vt[10] = mk(0, 0,      0,  3, 0, 0, 1, 0, 32'hA2, 0);
    vt[11] = mk(0, 0,      0,  2, 0, 0, 1, 0, 32'hA3, 0);
    vt[12] = mk(0, 0,      0,  1, 0, 0, 1, 1, 32'hA4, 0);
    vt[13] = mk(0, 0,      0,  0, 0, 0, 0, 0, 0,      0);
    vt[14] = mk(0, 0,      0,  0, 0, 0, 0, 0, 0,      1);
    vt[15] = mk(0, 0,      1,  0, 0, 0, 0, 0, 0,      0);
    vt[16] = mk(0, 0,      0,  0, 0, 0, 0, 0, 0,      0);
    vt[17] = mk(0, 0,      0,  0, 0, 0, 0, 0, 0,      1);
    vt[18] = mk(0, 0,      0,  0, 0, 0, 0, 0, 0,      0);

    reset = 1'b1; pcap_start = 1'b0; pcap_dat_valid = 1'b0; pcap_done = 1'b0;
    pcap_dat = '0; dma.m_ack_i = 1'b0; dma.m_dat_ready_i = 1'b0;

    // Reset
    repeat (5) cycle();
    chk("reset_outputs", 64'({dma_full, dma.m_req_o, dma.m_len_o, dma.m_dat_valid_o,
                              dma.m_last_o, fill, overflow, flush_done}), 64'd0);
    reset = 1'b0;
    cycle();
    chk("idle_after_reset", 64'({dma_full, dma.m_req_o, dma.m_dat_valid_o, fill,
                                 overflow, flush_done}), 64'd0);

    // Single full burst
    dma.m_ack_i = 1'b1; dma.m_dat_ready_i = 1'b1;
    clear_rx();
    write_words(0, 16);
    chk("burst_fill16", 64'({fill, dma.m_req_o}), 64'({11'd16, 1'b0}));
    cycle();
    chk("burst_req", 64'({dma.m_req_o, dma.m_len_o}), 64'({1'b1, 8'd16}));
    cycle();
    chk("burst_first_beat", 64'({dma.m_req_o, dma.m_dat_valid_o, dma.m_dat_o}),
        64'({1'b0, 1'b1, 32'd0}));
    wait_rx("burst_beats_seen", 16, 40);
    check_rx("burst", 0, 16, 16);
    chk("burst_lens", 64'({rx_len.size() == 1, rx_len.size() > 0 ? rx_len[0] : 8'd0}),
        64'({1'b1, 8'd16}));
    chk("burst_drained", 64'({fill, dma.m_dat_valid_o}), 64'd0);

    // Partial flush vector table
    for (int i = 0; i < 19; i++) begin
      pcap_dat_valid = vt[i].wr;
      pcap_dat       = vt[i].dat;
      pcap_done      = vt[i].done;
      act = {fill, dma.m_req_o, vt[i].req ? dma.m_len_o : 8'h0, dma.m_dat_valid_o,
             dma.m_last_o, vt[i].vld ? dma.m_dat_o : 32'h0, flush_done};
      exp = {vt[i].fill, vt[i].req, vt[i].len, vt[i].vld, vt[i].last, vt[i].mdat, vt[i].fdone};
      chk($sformatf("flush_vec%0d", i), 64'(act), 64'(exp));
      cycle();
    end
    pcap_dat_valid = 1'b0; pcap_done = 1'b0;

    // Back-pressure with random ready: 40 words as 16, 16, 8
    clear_rx();
    tw = 0; tbt = 0; track_bad = 0; track_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pcap_dat_valid = 1'b1;
      pcap_dat = 32'(100 + i);
      dma.m_dat_ready_i = 1'($urandom_range(0, 1));
      cycle();
    end
    pcap_dat_valid = 1'b0;
    pcap_done = 1'b1;
    cycle();
    pcap_done = 1'b0;
    wait_flush_done("bp_flush_done", 2000, 1'b1);
    track_en = 1'b0;
    check_rx("bp", 100, 40, 16);
    chk("bp_lens", 64'({8'(rx_len.size()),
                        rx_len.size() > 0 ? rx_len[0] : 8'd0,
                        rx_len.size() > 1 ? rx_len[1] : 8'd0,
                        rx_len.size() > 2 ? rx_len[2] : 8'd0}),
        64'({8'd3, 8'd16, 8'd16, 8'd8}));
    chk("bp_fill_track", 64'(track_bad), 64'd0);

    // Overflow with ack held low
    clear_rx();
    dma.m_ack_i = 1'b0;
    for (int k = 1; k <= 1030; k++) begin
      pcap_dat_valid = 1'b1;
      pcap_dat = 32'(k);
      cycle();
      if (k == 1007) chk("hw_below", 64'(dma_full), 64'd0);
      if (k == 1008) chk("hw_reached", 64'(dma_full), 64'd1);
    end
    pcap_dat_valid = 1'b0;
    chk("ovf_state", 64'({fill, overflow, dma_full, dma.m_req_o, dma.m_len_o}),
        64'({11'd1024, 1'b1, 1'b1, 1'b1, 8'd16}));
    dma.m_ack_i = 1'b1;
    pcap_done = 1'b1;
    cycle();
    pcap_done = 1'b0;
    wait_flush_done("ovf_flush_done", 3000, 1'b0);
    check_rx("ovf", 1, 1024, 16);
    bad_len = 0;
    foreach (rx_len[i]) if (rx_len[i] !== 8'd16) bad_len++;
    chk("ovf_lens", 64'({16'(rx_len.size()), 16'(bad_len)}), 64'({16'd64, 16'd0}));
    chk("ovf_sticky", 64'({overflow, fill, dma_full}), 64'({1'b1, 11'd0, 1'b0}));

    // Abort during beat 7, with a same-cycle write and done that must be ignored
    write_words(32'h600, 16);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (dma.m_dat_valid_o && dma.m_dat_o == 32'h606) found = 1'b1;
      else cycle();
    end
    chk("abort_beat7_seen", 64'(found), 64'd1);
    pcap_start = 1'b1; pcap_dat_valid = 1'b1; pcap_dat = 32'hBAD; pcap_done = 1'b1;
    cycle();
    pcap_start = 1'b0; pcap_dat_valid = 1'b0; pcap_done = 1'b0;
    chk("abort_state", 64'({dma.m_dat_valid_o, dma.m_req_o, fill, overflow, dma_full}), 64'd0);
    fd = 0;
    repeat (4) begin
      cycle();
      if (flush_done) fd++;
    end
    chk("abort_done_ignored", 64'({8'(fd), fill}), 64'd0);
    clear_rx();
    write_words(32'h700, 16);
    wait_rx("abort_new_beats_seen", 16, 80);
    check_rx("abort_new", 32'h700, 16, 16);
    chk("abort_new_lens", 64'({rx_len.size() == 1, rx_len.size() > 0 ? rx_len[0] : 8'd0}),
        64'({1'b1, 8'd16}));
    cycle();
    chk("abort_new_drained", 64'({fill, dma.m_dat_valid_o, overflow}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcap_dma_buffer.md
# pcap_dma_buffer

Buffering and burst-request stage directly downstream of the position-capture core. It accepts the 32-bit capture word stream (`pcap_dat` / `pcap_dat_valid`), stores it in an on-chip FIFO and presents it to the DMA engine as fixed-length write bursts through a request/acknowledge plus valid/ready handshake. It returns the `dma_full` back-pressure flag to the capture core and flushes any partial burst at end of capture.

## Interface
- `DEPTH`, 1024: FIFO depth in words; power of two, at least 2×`BURST`.
- `BURST`, 16: nominal burst length in words; 1..255.
- `HIGH_WATER`, `DEPTH`-16: fill level at or above which `dma_full_o` asserts.

- `clk_i` in 1: system clock.
- `reset_i` in 1: synchronous, active-high reset.
- `pcap_start_i` in 1: arm pulse. Clears the FIFO, error and flush state, and aborts any burst.
- `pcap_dat_i` in 32: capture data word.
- `pcap_dat_valid_i` in 1: write strobe for `pcap_dat_i`.
- `pcap_done_i` in 1: end-of-capture pulse. Requests a flush.
- `dma_full_o` out 1: registered high-water flag sent to the capture core.
- `m_req_o` out 1: burst request, held until acknowledged.
- `m_len_o` out 8: burst length in words, stable while `m_req_o`=1.
- `m_ack_i` in 1: request accepted.
- `m_dat_o` out 32: burst data (first-word fall-through).
- `m_dat_valid_o` out 1: burst data valid.
- `m_dat_ready_i` in 1: DMA engine accepts a beat.
- `m_last_o` out 1: final beat of the burst.
- `fill_o` out log2(`DEPTH`)+1: current FIFO occupancy.
- `overflow_o` out 1: sticky flag; a word was dropped because the FIFO was full.
- `flush_done_o` out 1: one-cycle pulse when a requested flush has completed.

## Operation
- **FIFO**
  - Write on `pcap_dat_valid_i` when fill < `DEPTH`.
  - Read on a beat (`m_dat_valid_o` & `m_dat_ready_i`).
  - A simultaneous read and write leaves fill unchanged. Read and write pointers wrap modulo `DEPTH`.
- **Overflow**
  - A write when fill = `DEPTH` is discarded and sets `overflow_o`.
  - `overflow_o` clears only on `reset_i` or `pcap_start_i`.
- **High water:** `dma_full_o` = registered (fill ≥ `HIGH_WATER`).
- **Flush request:** `pcap_done_i` sets `flush_pending`.
- **FSM states:** IDLE, REQ, XFER.
  - IDLE → REQ when fill ≥ `BURST`; `m_len_o` = `BURST`.
  - Otherwise IDLE → REQ when `flush_pending` and 0 < fill < `BURST`; `m_len_o` = fill (latched).
  - Otherwise, when `flush_pending` and fill = 0: pulse `flush_done_o`, clear `flush_pending`, stay in IDLE.
  - REQ: `m_req_o`=1. On `m_ack_i` → XFER and load `beats` = `m_len_o`.
  - XFER: `m_dat_valid_o`=1 (data is guaranteed present because `m_len_o` ≤ fill and only XFER drains the FIFO). Each beat decrements `beats`. `m_last_o` = (`beats`=1). After the last beat → IDLE.
- **Flush with a full burst available:** a flush arriving while fill ≥ `BURST` drains as full bursts first, then one partial burst, then `flush_done_o`.
- **`pcap_start_i`** (any state)
  - Next cycle: FSM in IDLE, pointers and fill = 0, `overflow_o`=0, `flush_pending`=0, `m_req_o`/`m_dat_valid_o`=0.
  - A write in the same cycle is discarded.
  - `pcap_done_i` in the same cycle is ignored.
- **Reset:** `reset_i` has the same effect as `pcap_start_i`.

## Timing
- Reset values: every output 0, except `m_dat_o`, which is don't-care.
- Write-to-fill latency: a word written in cycle N is reflected in `fill_o` and `dma_full_o` in cycle N+1.
- Request latency: `m_req_o` rises one cycle after fill reaches `BURST` with the FSM in IDLE.
- Request handshake: `m_ack_i` is sampled only while `m_req_o`=1. `m_req_o` drops the cycle after the ack.
- First beat: `m_dat_valid_o` rises the cycle after the ack. `m_dat_o` holds steady while valid=1 and ready=0.
- Burst turnaround: back-to-back bursts need at least one IDLE cycle between the last beat and the next `m_req_o`.
- Flush completion: `flush_done_o` pulses one cycle after IDLE is entered with fill = 0 and `flush_pending`=1.
- Sustained throughput: with ack and ready held high, the block sustains ≥ `BURST`/(`BURST`+3) words per cycle.

## Test plan
1. **Reset:** assert `reset_i` for 5 cycles → all outputs 0, `fill_o`=0.
2. **Single full burst:** write 16 words 0..15 with `m_ack_i`=`m_dat_ready_i`=1 → one request with `m_len_o`=16, 16 beats carrying 0..15 in order, `m_last_o` on beat 15 only, `fill_o` returns to 0.
3. **Partial flush:** write 5 words, then pulse `pcap_done_i` → request with `m_len_o`=5, 5 beats, `flush_done_o` pulse after the last beat. A second `pcap_done_i` with the FIFO empty → `flush_done_o` with no request.
4. **Back-pressure:** 40 words with `m_dat_ready_i` toggling pseudo-randomly → all data delivered in order as bursts of 16, 16, then a flush burst of 8. `fill_o` always equals writes minus beats.
5. **Overflow:** hold `m_ack_i`=0 and write 1030 words (`DEPTH`=1024) → `dma_full_o` rises the cycle after the 1008th write, `fill_o`=1024, `overflow_o`=1, words 1025..1030 are absent from later bursts.
6. **Abort mid-burst:** pulse `pcap_start_i` during beat 7 of a 16-beat burst → next cycle `m_dat_valid_o`=0, `fill_o`=0, `overflow_o`=0. New writes then produce a clean burst starting with the first new word.
